// File: rtl/strip_packer.sv
// First-fit rectangle placer over horizontal strips of increasing height.
// One request at a time: accept in IDLE, scan strips, pulse a response.
`timescale 1ns/1ps
module strip_packer #(
  parameter int CANVAS_W     = 128,
  parameter int CANVAS_H     = 128,
  parameter int N_STRIPS     = 12,
  parameter int MIN_H        = 4,
  parameter int DIM_W        = 5,
  parameter int IDX_W        = 8,
  parameter int STRIKE_W     = 4,
  parameter int STRIKE_LIMIT = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [DIM_W-1:0]                  height_i,
  input  logic [DIM_W-1:0]                  width_i,
  output logic                              rsp_valid_o,
  output logic                              placed_o,
  output logic [IDX_W-1:0]                  index_x_o,
  output logic [IDX_W-1:0]                  index_y_o,
  output logic [STRIKE_W-1:0]               strike_o,
  output logic                              halted_o,
  input  logic [$clog2(N_STRIPS)-1:0]       occ_sel_i,
  output logic [$clog2(CANVAS_W+1)-1:0]     occ_w_o
);

  localparam int SW      = $clog2(N_STRIPS);
  localparam int OW      = $clog2(CANVAS_W + 1);
  localparam int MAX_H   = MIN_H + N_STRIPS - 1;
  localparam int TOTAL_H = N_STRIPS * MIN_H + (N_STRIPS * (N_STRIPS - 1)) / 2;
  localparam logic [SW-1:0] LAST = SW'(N_STRIPS - 1);

  if (TOTAL_H > CANVAS_H) begin : g_bad_h
    $error("strip_packer: total strip height exceeds CANVAS_H");
  end
  if (STRIKE_LIMIT > (2 ** STRIKE_W) - 1) begin : g_bad_lim
    $error("strip_packer: STRIKE_LIMIT does not fit STRIKE_W");
  end

  typedef enum logic [1:0] {IDLE, SCAN, RESP, HALT} state_e;

  state_e              state_q, state_d;
  logic [DIM_W-1:0]    w_q, w_d;
  logic                bad_q, bad_d;
  logic [SW-1:0]       idx_q, idx_d;
  logic [OW-1:0]       occ_q [N_STRIPS];
  logic [OW-1:0]       occ_d [N_STRIPS];
  logic                placed_q, placed_d;
  logic [IDX_W-1:0]    x_q, x_d;
  logic [IDX_W-1:0]    y_q, y_d;
  logic [STRIKE_W-1:0] strike_q, strike_d;

  logic [IDX_W-1:0]    y_tab [N_STRIPS];
  logic [OW:0]         sum;
  logic                fit;
  logic                req_bad;
  logic [SW-1:0]       start_idx;

  for (genvar k = 0; k < N_STRIPS; k++) begin : g_y
    assign y_tab[k] = IDX_W'(k * MIN_H + (k * (k - 1)) / 2);
  end

  assign req_bad = (height_i == '0) || (32'(height_i) > MAX_H)
                || (width_i == '0) || (32'(width_i) > CANVAS_W);
  assign start_idx = (32'(height_i) > MIN_H)
                   ? SW'(32'(height_i) - MIN_H) : '0;

  // One bit wider than occupancy so the sum cannot wrap.
  assign sum = {1'b0, occ_q[idx_q]} + (OW+1)'(w_q);
  assign fit = sum <= (OW+1)'(CANVAS_W);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    bad_d    = bad_q;
    idx_d    = idx_q;
    occ_d    = occ_q;
    placed_d = placed_q;
    x_d      = x_q;
    y_d      = y_q;
    strike_d = strike_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          w_d     = width_i;
          bad_d   = req_bad;
          idx_d   = req_bad ? '0 : start_idx;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!bad_q && fit) begin
          placed_d     = 1'b1;
          x_d          = IDX_W'(occ_q[idx_q]);
          y_d          = y_tab[idx_q];
          occ_d[idx_q] = sum[OW-1:0];
          state_d      = RESP;
        end else if (!bad_q && idx_q != LAST) begin
          idx_d = idx_q + 1'b1;
        end else begin
          placed_d = 1'b0;
          x_d      = '1;
          y_d      = '1;
          if (strike_q != '1) strike_d = strike_q + 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = (strike_q == STRIKE_W'(STRIKE_LIMIT)) ? HALT : IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      w_q      <= '0;
      bad_q    <= 1'b0;
      idx_q    <= '0;
      placed_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      strike_q <= '0;
      for (int i = 0; i < N_STRIPS; i++) occ_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      bad_q    <= bad_d;
      idx_q    <= idx_d;
      placed_q <= placed_d;
      x_q      <= x_d;
      y_q      <= y_d;
      strike_q <= strike_d;
      occ_q    <= occ_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign halted_o    = (state_q == HALT);
  assign placed_o    = placed_q;
  assign index_x_o   = x_q;
  assign index_y_o   = y_q;
  assign strike_o    = strike_q;

  always_comb begin
    occ_w_o = '0;
    if (32'(occ_sel_i) < N_STRIPS) occ_w_o = occ_q[occ_sel_i];
  end

endmodule
